// File: rtl/control_fsm_pkg.sv
// Shared encodings for the multicycle control FSM: state codes, opcodes and
// the selector values driven onto the datapath muxes.
package control_fsm_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_EXEC     = 4'd6,
        ST_ALU_WB   = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_JUMP     = 4'd9
    } state_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRC_B_REG   = 2'b00;
    localparam logic [1:0] SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] SRC_B_IMM   = 2'b10;
    localparam logic [1:0] SRC_B_SHIFT = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    function automatic logic is_supported(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J);
    endfunction

endpackage

// File: rtl/control_fsm.sv
// Multicycle CPU control unit: Moore FSM whose outputs decode the registered
// state, with only the fetch strobes and wait states qualified by mem_ready.
module control_fsm
    import control_fsm_pkg::*;
#(
    parameter bit WAIT_MEM = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic [1:0] alu_op,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_d;
    logic   ready;

    // Without a memory handshake every access completes in its first cycle.
    assign ready = WAIT_MEM ? mem_ready : 1'b1;
    assign state = state_q;

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_FETCH;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH:    state_d = ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_R:         state_d = ST_EXEC;
                    OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    default:      state_d = ST_FETCH;
                endcase
            end
            ST_MEM_ADDR: state_d = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   state_d = ready ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WR:   state_d = ready ? ST_FETCH : ST_MEM_WR;
            ST_MEM_WB:   state_d = ST_FETCH;
            ST_EXEC:     state_d = ST_ALU_WB;
            ST_ALU_WB:   state_d = ST_FETCH;
            ST_BRANCH:   state_d = ST_FETCH;
            ST_JUMP:     state_d = ST_FETCH;
            default:     state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        alu_op        = ALU_OP_ADD;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_REG;
        pc_source     = PC_SRC_ALU;
        illegal_op    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                ir_write  = ready;
                pc_write  = ready;
            end
            ST_DECODE: begin
                alu_src_b  = SRC_B_SHIFT;
                illegal_op = !is_supported(opcode);
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            ST_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            ST_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_FUNCT;
            end
            ST_ALU_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_OP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_SRC_ALUOUT;
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PC_SRC_JUMP;
            end
            default: ;
        endcase
        // Reset must squash every side-effecting strobe immediately, even mid-access.
        if (reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            illegal_op    = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Drives two control_fsm instances (memory handshake on and off) with directed
// then random stimulus and compares both against an instruction-route model.
module tb_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       mem_ready;
    logic [5:0] opcode_a, opcode_b;

    logic [1:0] alu_op_a, alu_src_b_a, pc_source_a;
    logic       pc_write_a, pc_write_cond_a, i_or_d_a, mem_read_a, mem_write_a;
    logic       ir_write_a, reg_dst_a, reg_write_a, mem_to_reg_a, alu_src_a_a, illegal_op_a;
    logic [3:0] state_a;

    logic [1:0] alu_op_b, alu_src_b_b, pc_source_b;
    logic       pc_write_b, pc_write_cond_b, i_or_d_b, mem_read_b, mem_write_b;
    logic       ir_write_b, reg_dst_b, reg_write_b, mem_to_reg_b, alu_src_a_b, illegal_op_b;
    logic [3:0] state_b;

    int vectors = 0;
    int miscompares = 0;

    int m_state [2];
    int m_route [2][4];
    int m_len   [2];
    int m_ptr   [2];

    always #5 clk = ~clk;

    control_fsm #(.WAIT_MEM(1'b1)) dut_a (
        .clk(clk), .reset(reset), .opcode(opcode_a), .mem_ready(mem_ready),
        .alu_op(alu_op_a), .pc_write(pc_write_a), .pc_write_cond(pc_write_cond_a),
        .i_or_d(i_or_d_a), .mem_read(mem_read_a), .mem_write(mem_write_a),
        .ir_write(ir_write_a), .reg_dst(reg_dst_a), .reg_write(reg_write_a),
        .mem_to_reg(mem_to_reg_a), .alu_src_a(alu_src_a_a), .alu_src_b(alu_src_b_a),
        .pc_source(pc_source_a), .illegal_op(illegal_op_a), .state(state_a)
    );

    control_fsm #(.WAIT_MEM(1'b0)) dut_b (
        .clk(clk), .reset(reset), .opcode(opcode_b), .mem_ready(mem_ready),
        .alu_op(alu_op_b), .pc_write(pc_write_b), .pc_write_cond(pc_write_cond_b),
        .i_or_d(i_or_d_b), .mem_read(mem_read_b), .mem_write(mem_write_b),
        .ir_write(ir_write_b), .reg_dst(reg_dst_b), .reg_write(reg_write_b),
        .mem_to_reg(mem_to_reg_b), .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b),
        .pc_source(pc_source_b), .illegal_op(illegal_op_b), .state(state_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit is_known(input logic [5:0] op);
        case (op)
            6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Packed as {alu_op, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    //            reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b, pc_source, illegal_op}
    function automatic logic [16:0] exp_bundle(input int st, input bit rdy, input bit rst, input logic [5:0] op);
        logic [1:0] aop, srcb, pcs;
        logic pcw, pcwc, iod, mrd, mwr, irw, rdst, rwr, m2r, srca, ill;
        {aop, srcb, pcs} = '0;
        {pcw, pcwc, iod, mrd, mwr, irw, rdst, rwr, m2r, srca, ill} = '0;
        case (st)
            0: begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
            1: begin srcb = 2'b11; ill = !is_known(op); end
            2: begin srca = 1; srcb = 2'b10; end
            3: begin mrd = 1; iod = 1; end
            4: begin m2r = 1; rwr = 1; end
            5: begin mwr = 1; iod = 1; end
            6: begin srca = 1; aop = 2'b10; end
            7: begin rdst = 1; rwr = 1; end
            8: begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            9: begin pcw = 1; pcs = 2'b10; end
            default: ;
        endcase
        if (rst) {pcw, pcwc, irw, rwr, mrd, mwr, ill} = '0;
        return {aop, pcw, pcwc, iod, mrd, mwr, irw, rdst, rwr, m2r, srca, srcb, pcs, ill};
    endfunction

    // Each instruction is a fixed route of states after FETCH; memory states stall on ready.
    task automatic modelStep(input int idx, input bit rdy, input bit rst, input logic [5:0] op);
        bit is_mem;
        if (rst) begin
            m_state[idx] = 0; m_len[idx] = 0; m_ptr[idx] = 0;
            return;
        end
        is_mem = (m_state[idx] == 0) || (m_state[idx] == 3) || (m_state[idx] == 5);
        if (is_mem && !rdy) return;
        if (m_state[idx] == 0) begin
            m_route[idx][0] = 1;
            case (op)
                6'b000000: begin m_route[idx][1] = 6; m_route[idx][2] = 7; m_len[idx] = 3; end
                6'b100011: begin m_route[idx][1] = 2; m_route[idx][2] = 3; m_route[idx][3] = 4; m_len[idx] = 4; end
                6'b101011: begin m_route[idx][1] = 2; m_route[idx][2] = 5; m_len[idx] = 3; end
                6'b000100: begin m_route[idx][1] = 8; m_len[idx] = 2; end
                6'b000010: begin m_route[idx][1] = 9; m_len[idx] = 2; end
                default:   m_len[idx] = 1;
            endcase
            m_ptr[idx] = 0;
        end
        if (m_ptr[idx] < m_len[idx]) begin
            m_state[idx] = m_route[idx][m_ptr[idx]];
            m_ptr[idx]++;
        end else begin
            m_state[idx] = 0;
        end
    endtask

    // Opcode only changes while an instance sits in FETCH, as a real IR would.
    task automatic applyStimulus(input bit rst, input bit rdy, input logic [5:0] op);
        @(negedge clk);
        reset = rst;
        mem_ready = rdy;
        if (m_state[0] == 0) opcode_a = op;
        if (m_state[1] == 0) opcode_b = op;
        #1;
        checkOutput($sformatf("state_a@%0t", $time), {28'd0, state_a}, m_state[0]);
        checkOutput($sformatf("outs_a@%0t st%0d", $time, m_state[0]),
            {15'd0, alu_op_a, pc_write_a, pc_write_cond_a, i_or_d_a, mem_read_a, mem_write_a,
             ir_write_a, reg_dst_a, reg_write_a, mem_to_reg_a, alu_src_a_a, alu_src_b_a,
             pc_source_a, illegal_op_a},
            {15'd0, exp_bundle(m_state[0], rdy, rst, opcode_a)});
        checkOutput($sformatf("state_b@%0t", $time), {28'd0, state_b}, m_state[1]);
        checkOutput($sformatf("outs_b@%0t st%0d", $time, m_state[1]),
            {15'd0, alu_op_b, pc_write_b, pc_write_cond_b, i_or_d_b, mem_read_b, mem_write_b,
             ir_write_b, reg_dst_b, reg_write_b, mem_to_reg_b, alu_src_a_b, alu_src_b_b,
             pc_source_b, illegal_op_b},
            {15'd0, exp_bundle(m_state[1], 1'b1, rst, opcode_b)});
        @(posedge clk);
        modelStep(0, rdy, rst, opcode_a);
        modelStep(1, 1'b1, rst, opcode_b);
    endtask

    typedef struct { bit rst; bit rdy; logic [5:0] op; } step_t;

    initial begin
        step_t dir [$];
        logic [5:0] ops [6];
        ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
        ops[3] = 6'b000100; ops[4] = 6'b000010; ops[5] = 6'b111111;

        reset = 1'b1; mem_ready = 1'b0; opcode_a = '0; opcode_b = '0;
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0; m_len[i] = 0; m_ptr[i] = 0;
        end
        repeat (2) @(posedge clk);

        dir.push_back('{1, 1, 6'b000000});
        repeat (5) dir.push_back('{0, 1, 6'b000000});
        repeat (3) dir.push_back('{0, 1, 6'b100011});
        repeat (3) dir.push_back('{0, 0, 6'b100011});
        repeat (3) dir.push_back('{0, 1, 6'b100011});
        repeat (2) dir.push_back('{0, 0, 6'b000100});
        repeat (4) dir.push_back('{0, 1, 6'b000100});
        repeat (3) dir.push_back('{0, 1, 6'b000010});
        repeat (3) dir.push_back('{0, 1, 6'b111111});
        repeat (3) dir.push_back('{0, 1, 6'b101011});
        dir.push_back('{0, 0, 6'b101011});
        dir.push_back('{1, 0, 6'b101011});
        repeat (2) dir.push_back('{0, 1, 6'b000000});

        foreach (dir[i]) applyStimulus(dir[i].rst, dir[i].rdy, dir[i].op);

        for (int i = 0; i < 3000; i++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            applyStimulus($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 7, op);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameter: WAIT_MEM, default 1, meaning 1 = memory states wait on mem_ready and 0 = mem_ready ignored (treated as 1).
REQ-002 Port clk: input, 1 bit, the single clock; all state changes on posedge clk.
REQ-003 Port reset: input, 1 bit, synchronous, active-high.
REQ-004 Port opcode: input, 6 bits, instruction[31:26] from the instruction register.
REQ-005 Port mem_ready: input, 1 bit, memory access completes this cycle.
REQ-006 Port alu_op: output, 2 bits, ALU-control selector (00 add, 01 sub, 10 funct-decode).
REQ-007 Ports pc_write and pc_write_cond: outputs, 1 bit each; PC unconditional write; PC write qualified by ALU zero.
REQ-008 Ports i_or_d, mem_read, mem_write, ir_write: outputs, 1 bit each; address select (0 = PC, 1 = ALUOut), memory strobes, IR load.
REQ-009 Ports reg_dst, reg_write, mem_to_reg: outputs, 1 bit each; rd/rt select, regfile write, writeback select.
REQ-010 Port alu_src_a: output, 1 bit (0 = PC, 1 = A); port alu_src_b: output, 2 bits (00 B, 01 const 4, 10 sign-ext imm, 11 shifted imm).
REQ-011 Port pc_source: output, 2 bits (00 ALU, 01 ALUOut, 10 jump target).
REQ-012 Port illegal_op: output, 1 bit, one-cycle pulse on unsupported opcode; port state: output, 4 bits, current state encoding.

Function
REQ-013 Moore FSM with states FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, ALU_WB=7, BRANCH=8, JUMP=9; all outputs are decoded from the registered state only, except the mem_ready gating in REQ-014/REQ-018.
REQ-014 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write and pc_write = mem_ready; advance to DECODE only when mem_ready=1.
REQ-015 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next state by opcode: 000000 to EXEC, 100011 or 101011 to MEM_ADDR, 000100 to BRANCH, 000010 to JUMP, any other value to FETCH with illegal_op=1 for this cycle.
REQ-016 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; next state MEM_RD if opcode=100011, else MEM_WR.
REQ-017 MEM_RD: mem_read=1, i_or_d=1; hold until mem_ready, then MEM_WB.
REQ-018 MEM_WR: mem_write=1, i_or_d=1; hold until mem_ready, then FETCH.
REQ-019 MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1; then FETCH.
REQ-020 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; then ALU_WB.
REQ-021 ALU_WB: reg_dst=1, mem_to_reg=0, reg_write=1; then FETCH.
REQ-022 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; then FETCH.
REQ-023 JUMP: pc_write=1, pc_source=10; then FETCH.
REQ-024 Outputs not listed for a state SHALL be 0.
REQ-025 Latency with mem_ready=1: R-type 4 cycles, lw 5, sw 4, beq 3, j 3.
REQ-026 Unused state codes 10-15 SHALL go to FETCH on the next edge with all outputs 0.
REQ-027 When WAIT_MEM=0, every wait in FETCH, MEM_RD and MEM_WR lasts exactly 1 cycle.

Reset
REQ-028 On a posedge with reset=1, state becomes FETCH, from any state including mid-access waits.
REQ-029 While reset=1, pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write and illegal_op are forced to 0.
REQ-030 The first FETCH after reset deasserts behaves as in REQ-014.

Structure
REQ-031 A shared package holds the state encodings, the opcode constants (R, LW, SW, BEQ, J) and the ALU_OP_ADD/SUB/FUNCT codes.
REQ-032 Single module with no sub-module; next-state and output decoding are separate combinational blocks, plus one state register.

Verification
REQ-033 Reset then add (opcode 000000, mem_ready=1): states 0,1,6,7,0; reg_write=1 and reg_dst=1 in cycle 4 only; alu_op=10 in EXEC.
REQ-034 lw (100011) with mem_ready low for 3 cycles in MEM_RD: state 3 held 4 cycles, mem_read=1 and i_or_d=1 throughout, then MEM_WB with mem_to_reg=1.
REQ-035 FETCH with mem_ready=0 for 2 cycles: ir_write=0 and pc_write=0 while waiting, both 1 in the single ready cycle, then DECODE.
REQ-036 beq (000100): states 0,1,8,0; pc_write_cond=1, alu_op=01, pc_source=01 in BRANCH; j (000010): pc_write=1, pc_source=10 in JUMP.
REQ-037 Opcode 111111 in DECODE: illegal_op=1 for 1 cycle, next state FETCH, no write strobes asserted.
REQ-038 reset asserted during MEM_WR wait: mem_write drops to 0 in the same cycle and state=0 after the edge.
